uart_rx_byte: RTL and testbench
===============================

// Module: uart_rx_byte
// PURPOSE
//  UART receiver: deserialises an 8N1 line (LSB first, start=0, stop=1) into bytes.
//  Sits on the RX pin directly opposite the TX serialiser, at the same bit timing
//  (218 clk per bit at the default setting).
//  Presents each byte through a one-entry valid/ready holding register to the buffer logic.
// PARAMETERS
//  CLKS_PER_BIT  218  clk cycles per bit; must be >= 4; HALF = CLKS_PER_BIT/2 (floor)
//  DATA_BITS     8    payload bits per frame (fixed 8 in this revision)
// PORTS
//  clk         in   1  single clock, all logic on posedge
//  rst         in   1  synchronous, active-high reset
//  rx_data     in   1  asynchronous serial line, idle high
//  dout        out  8  received byte, stable while dout_valid=1
//  dout_valid  out  1  byte available; held until accepted
//  dout_ready  in   1  consumer accepts on dout_valid & dout_ready
//  busy        out  1  1 when state != IDLE
//  frame_err   out  1  1-cycle pulse: stop bit sampled 0, byte discarded
//  overrun     out  1  1-cycle pulse: byte completed while holding reg full, new byte dropped
// BEHAVIOUR
//  Reset: dout=0, dout_valid=0, busy=0, frame_err=0, overrun=0; state=IDLE; cnt=0; bit_idx=0;
//   2-flop synchroniser and edge-history flop all reset to 0, so a line held low
//   through reset never starts a frame. Reset mid-frame discards the partial byte.
//  rx_s = synchronised line (2-cycle latency); start detect = rx_s_prev=1 & rx_s=0.
//  FSM (cnt cleared on every state change):
//   IDLE : falling edge -> START.
//   START: cnt==HALF-1: rx_s=0 -> DATA; rx_s=1 -> IDLE (glitch reject, no flag).
//   DATA : cnt==CLKS_PER_BIT-1: shift sampled bit into sr[7] (right shift, LSB first),
//          bit_idx++; after 8th bit -> STOP, bit_idx=0.
//   STOP : cnt==CLKS_PER_BIT-1 (mid stop bit): sample=1 -> deliver sr; sample=0 ->
//          frame_err pulse; both -> IDLE. Returning at mid-stop allows back-to-back frames.
//  Delivery, registered, effective cycle after the stop sample:
//   holding empty, or full & dout_ready that cycle -> dout<=sr, dout_valid<=1.
//   full & !dout_ready -> overrun pulse, dout unchanged.
//   dout_ready with no delivery -> dout_valid<=0 next cycle.
//  Frame error never touches dout/dout_valid. Sampled values are the voted bit when
//   UART_RX_MAJORITY_EN is defined (see CONFIGURATION).
//  cnt: 16-bit, saturation impossible (cleared at each terminal).
// CONFIGURATION
//  UART_RX_MAJORITY_EN defined: 3-bit window of last rx_s values; every sample point
//   (START check, DATA, STOP) uses the 2-of-3 majority of rx_s at cnt-2, cnt-1, cnt.
//   No timing change. Window resets to 000.
//  Undefined: single sample of rx_s at the sample point; window logic absent.
// STRUCTURE
//  Shared header uart_defs.vh: state encodings (IDLE/START/DATA/STOP), default
//   CLKS_PER_BIT=218, DATA_BITS=8; shared with the TX side.
//  Sub-module uart_rx_sync: 2-flop synchroniser + edge-history flop;
//   outputs rx_s and fall_edge.
// TESTING (sim with CLKS_PER_BIT=16)
//  1. Send 0xA5 with dout_ready=0 -> dout=0xA5, dout_valid=1, held; dout_ready=1 for
//     1 cycle -> dout_valid=0 next cycle.
//  2. 0x3C then 0xC3 back-to-back, dout_ready=1 -> two accepts in order, no
//     frame_err/overrun.
//  3. 0x55 with stop bit driven 0 -> frame_err 1-cycle pulse, dout_valid stays 0;
//     next 0x12 received correctly.
//  4. 0x11 unaccepted, then 0x22 -> overrun pulse, dout stays 0x11; accept -> 0x22 lost.
//  5. 3-cycle low glitch on idle line -> START then IDLE, no valid, busy high <=HALF+2 cycles.
//  6. rst asserted mid-DATA of 0xFF with line low -> all outputs 0; line held low
//     after reset -> no frame until a new falling edge; with UART_RX_MAJORITY_EN,
//     1-cycle inverted spike at a DATA sample point -> byte unaffected.

Source files
------------

// File: rtl/uart_rx_byte_pkg.sv
// Shared definitions for the UART byte receiver: FSM state encoding,
// default bit timing, frame width and the 2-of-3 vote helper.
package uart_rx_byte_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

  localparam int CLKS_PER_BIT_DEF = 218;
  localparam int DATA_BITS        = 8;

  // 2-of-3 majority of three line samples
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous RX line plus one history flop
// used to detect the 1->0 transition that opens a frame. All flops reset
// to 0, so a line that is low when reset releases never looks like an edge.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx_data,
  output logic rx_s,
  output logic fall_edge
);

  logic sync_1;
  logic sync_2;
  logic rx_prev;

  // metastability filter and one cycle of edge history
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1  <= 1'b0;
      sync_2  <= 1'b0;
      rx_prev <= 1'b0;
    end else begin
      sync_1  <= rx_data;
      sync_2  <= sync_1;
      rx_prev <= sync_2;
    end
  end

  assign rx_s      = sync_2;
  assign fall_edge = rx_prev & ~sync_2;

endmodule

// File: rtl/uart_rx_byte.sv
// UART 8N1 receiver (LSB first) with a one-entry holding register.
// Optional build macro: UART_RX_MAJORITY_EN -- every sample point uses the
// 2-of-3 vote over the last three synchronised line values.
//
// Output handshake: dout/dout_valid form a valid/ready source. A byte is
// transferred on any clock edge where dout_valid & dout_ready are both 1;
// dout is stable and dout_valid stays high until that edge. A new byte that
// completes while the register is full and not being accepted is dropped
// with a one-cycle overrun pulse.
module uart_rx_byte
  import uart_rx_byte_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_data,
  output logic [7:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun,
  output logic [1:0] state_dbg
);

  localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] BIT_M1  = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

  rx_state_t   state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [7:0]  sr, sr_n;
  logic        stop_ok;
  logic        stop_bad;
  logic        rx_s;
  logic        fall_edge;
  logic        sample;

  uart_rx_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_s      (rx_s),
    .fall_edge (fall_edge)
  );

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist;

  // two previous synchronised values; with rx_s they form the vote window
  always_ff @(posedge clk) begin
    if (rst) hist <= 2'b00;
    else     hist <= {hist[0], rx_s};
  end

  assign sample = maj3(hist[1], hist[0], rx_s);
`else
  assign sample = rx_s;
`endif

  // next-state, bit counter and shift register update
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 16'd1;
    bit_idx_n = bit_idx;
    sr_n      = sr;
    stop_ok   = 1'b0;
    stop_bad  = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_n = '0;
        if (fall_edge) state_n = ST_START;
      end
      ST_START: begin
        if (cnt == HALF_M1) begin
          cnt_n   = '0;
          // a line back high at mid start bit was a glitch
          state_n = sample ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt == BIT_M1) begin
          cnt_n = '0;
          sr_n  = {sample, sr[7:1]};
          if (bit_idx == LAST_BIT) begin
            bit_idx_n = '0;
            state_n   = ST_STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (cnt == BIT_M1) begin
          // leave at mid stop bit so a following start edge is not missed
          cnt_n    = '0;
          state_n  = ST_IDLE;
          stop_ok  = sample;
          stop_bad = ~sample;
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = ST_IDLE;
      end
    endcase
  end

  // FSM registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      sr      <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      sr      <= sr_n;
    end
  end

  // holding register, status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      overrun   <= 1'b0;
      if (stop_ok) begin
        if (!dout_valid || dout_ready) begin
          dout       <= sr;
          dout_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at 16 clocks per bit.
module tb_uart_rx_byte;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_data = 1'b1;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready = 1'b0;
  logic       busy;
  logic       frame_err;
  logic       overrun;
  logic [1:0] state_dbg;

  int total = 0;
  int bad   = 0;

  // accepted bytes and pulse counters collected by the monitor
  logic [7:0] acc_q[$];
  logic [7:0] exp_q[$];
  int fe_cnt   = 0;
  int ov_cnt   = 0;
  int busy_run = 0;
  int busy_max = 0;

  uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .state_dbg  (state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  // monitor
  always @(posedge clk) begin
    if (dout_valid && dout_ready) acc_q.push_back(dout);
    if (frame_err) fe_cnt++;
    if (overrun)   ov_cnt++;
    if (busy) begin
      busy_run++;
      if (busy_run > busy_max) busy_max = busy_run;
    end else begin
      busy_run = 0;
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic clear_stats();
    acc_q.delete();
    exp_q.delete();
    fe_cnt   = 0;
    ov_cnt   = 0;
    busy_run = 0;
    busy_max = 0;
  endtask

  // one frame; spike_bit >= 0 inverts the line for one cycle at that data bit's sample point
  task automatic send_frame(input logic [7:0] b, input logic stop_val, input int spike_bit);
    logic v;
    for (int i = 0; i < 10; i++) begin
      if (i == 0)      v = 1'b0;
      else if (i == 9) v = stop_val;
      else             v = b[i-1];
      for (int k = 0; k < CPB; k++) begin
        if (spike_bit >= 0 && i == spike_bit + 1 && k == 8) rx_data = ~v;
        else                                                  rx_data = v;
        @(negedge clk);
      end
    end
    rx_data = 1'b1;
  endtask

  task automatic pulse_ready();
    dout_ready = 1'b1;
    @(negedge clk);
    dout_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(4);
    total++; if (dout !== 8'h00)     begin bad++; $display("FAIL reset_dout got=%h exp=00", dout); end
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", dout_valid); end
    total++; if ({busy, frame_err, overrun} !== 3'b000)
      begin bad++; $display("FAIL reset_flags got=%b exp=000", {busy, frame_err, overrun}); end
    rst = 1'b0;
    idle(10);
  endtask

  task automatic test_hold_and_accept();
    clear_stats();
    dout_ready = 1'b0;
    send_frame(8'hA5, 1'b1, -1);
    total++; if (dout_valid !== 1'b1) begin bad++; $display("FAIL hold_valid got=%b exp=1", dout_valid); end
    total++; if (dout !== 8'hA5)      begin bad++; $display("FAIL hold_dout got=%h exp=a5", dout); end
    idle(20);
    total++; if (dout_valid !== 1'b1 || dout !== 8'hA5)
      begin bad++; $display("FAIL hold_stable got=%b/%h exp=1/a5", dout_valid, dout); end
    pulse_ready();
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL accept_clear got=%b exp=0", dout_valid); end
    total++; if (acc_q.size() !== 1 || acc_q[0] !== 8'hA5)
      begin bad++; $display("FAIL accept_byte got_n=%0d exp_n=1", acc_q.size()); end
    idle(5);
  endtask

  task automatic test_back_to_back();
    clear_stats();
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    dout_ready = 1'b1;
    send_frame(8'h3C, 1'b1, -1);
    send_frame(8'hC3, 1'b1, -1);
    idle(4);
    dout_ready = 1'b0;
    total++; if (acc_q.size() !== exp_q.size())
      begin bad++; $display("FAIL b2b_count got=%0d exp=%0d", acc_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) begin
      total++; if (acc_q[i] !== exp_q[i])
        begin bad++; $display("FAIL b2b_byte%0d got=%h exp=%h", i, acc_q[i], exp_q[i]); end
    end
    total++; if (fe_cnt != 0 || ov_cnt != 0)
      begin bad++; $display("FAIL b2b_flags got fe=%0d ov=%0d exp=0/0", fe_cnt, ov_cnt); end
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL b2b_valid got=%b exp=0", dout_valid); end
  endtask

  task automatic test_frame_error();
    clear_stats();
    dout_ready = 1'b0;
    send_frame(8'h55, 1'b0, -1);
    idle(10);
    total++; if (fe_cnt != 1)         begin bad++; $display("FAIL ferr_pulse got=%0d exp=1", fe_cnt); end
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL ferr_valid got=%b exp=0", dout_valid); end
    send_frame(8'h12, 1'b1, -1);
    total++; if (dout_valid !== 1'b1 || dout !== 8'h12)
      begin bad++; $display("FAIL ferr_next got=%b/%h exp=1/12", dout_valid, dout); end
    pulse_ready();
    idle(5);
  endtask

  task automatic test_overrun();
    clear_stats();
    dout_ready = 1'b0;
    send_frame(8'h11, 1'b1, -1);
    send_frame(8'h22, 1'b1, -1);
    idle(3);
    total++; if (ov_cnt != 1)     begin bad++; $display("FAIL ovr_pulse got=%0d exp=1", ov_cnt); end
    total++; if (dout !== 8'h11)  begin bad++; $display("FAIL ovr_dout got=%h exp=11", dout); end
    pulse_ready();
    idle(3);
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL ovr_valid got=%b exp=0", dout_valid); end
    total++; if (acc_q.size() !== 1 || acc_q[0] !== 8'h11)
      begin bad++; $display("FAIL ovr_lost got_n=%0d exp_n=1", acc_q.size()); end
  endtask

  task automatic test_glitch();
    clear_stats();
    rx_data = 1'b0;
    idle(3);
    rx_data = 1'b1;
    idle(3 * CPB);
    total++; if (busy_max < 1 || busy_max > HALF + 2)
      begin bad++; $display("FAIL glitch_busy got=%0d exp=1..%0d", busy_max, HALF + 2); end
    total++; if (dout_valid !== 1'b0 || fe_cnt != 0)
      begin bad++; $display("FAIL glitch_valid got=%b fe=%0d exp=0/0", dout_valid, fe_cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_idle got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid_frame();
    clear_stats();
    rx_data = 1'b0;
    idle(CPB);
    rx_data = 1'b1;
    idle(3 * CPB);
    rx_data = 1'b0;
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(1);
    total++; if ({dout, dout_valid, busy, frame_err, overrun} !== 12'h000)
      begin bad++; $display("FAIL midrst_outs got=%h/%b/%b exp=00/0/0", dout, dout_valid, busy); end
    busy_max = 0;
    idle(4 * CPB);
    total++; if (busy_max != 0 || dout_valid !== 1'b0)
      begin bad++; $display("FAIL midrst_low got busy=%0d valid=%b exp=0/0", busy_max, dout_valid); end
    rx_data = 1'b1;
    idle(2 * CPB);
    send_frame(8'h0F, 1'b1, -1);
    total++; if (dout_valid !== 1'b1 || dout !== 8'h0F)
      begin bad++; $display("FAIL midrst_next got=%b/%h exp=1/0f", dout_valid, dout); end
    pulse_ready();
    idle(5);
  endtask

`ifdef UART_RX_MAJORITY_EN
  task automatic test_majority_spike();
    clear_stats();
    send_frame(8'h96, 1'b1, 3);
    total++; if (dout_valid !== 1'b1 || dout !== 8'h96)
      begin bad++; $display("FAIL maj_spike got=%b/%h exp=1/96", dout_valid, dout); end
    pulse_ready();
    idle(5);
  endtask
`endif

  initial begin
    idle(1);
    test_reset();
    test_hold_and_accept();
    test_back_to_back();
    test_frame_error();
    test_overrun();
    test_glitch();
    test_reset_mid_frame();
`ifdef UART_RX_MAJORITY_EN
    test_majority_spike();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
